// File: rtl/heartbeat.sv
// Periodic keep-alive generator: raises a beat request every period*(div+1) clocks
// and holds it on a req/ack level handshake; flags beats that come due while unacknowledged.
module heartbeat #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] period,
  input  logic [D-1:0] div,
  input  logic         enable,
  input  logic         beat_ack,
  output logic         beat,
  output logic         missed,
  output logic [W-1:0] phase,
  output logic         busy
);

  // Handshake: beat is the request, beat_ack the acknowledge. A request rises on a
  // due event and falls only on an edge where beat_ack=1 and no new beat is due.
  typedef enum logic {IDLE, RUN} state_t;

  state_t       state;
  logic [D-1:0] pre;
  logic         due;

  always_comb begin
    due = (state == RUN) && enable && (pre == '0) && (phase == W'(1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      phase  <= '0;
      pre    <= '0;
      beat   <= 1'b0;
      missed <= 1'b0;
    end else begin
      missed <= 1'b0;

      case (state)
        IDLE: begin
          if (enable && (period != '0)) begin
            state <= RUN;
            busy  <= 1'b1;
            phase <= period;
            pre   <= div;
          end
        end
        RUN: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
            phase <= '0;
            pre   <= '0;
          end else if (pre != '0) begin
            pre <= pre - D'(1);
          end else begin
            pre <= div;
            if (phase == W'(1)) begin
              // Reload samples period here; a zero period stops the run after this beat.
              phase <= period;
              if (period == '0) begin
                state <= IDLE;
                busy  <= 1'b0;
                pre   <= '0;
              end
            end else begin
              phase <= phase - W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (due) begin
        beat <= 1'b1;
        if (beat && !beat_ack) missed <= 1'b1;
      end else if (beat && beat_ack) begin
        beat <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_heartbeat.sv
// Directed bench for heartbeat: each task drives one scenario and checks
// {busy, beat, missed, phase} against hand-computed values after every edge.
module tb_heartbeat;
  localparam int W = 8;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] period;
  logic [D-1:0] div;
  logic         enable;
  logic         beat_ack;
  logic         beat;
  logic         missed;
  logic [W-1:0] phase;
  logic         busy;

  int checks = 0;
  int errors = 0;

  heartbeat #(.W(W), .D(D)) dut (
    .clock(clock), .reset(reset), .period(period), .div(div), .enable(enable),
    .beat_ack(beat_ack), .beat(beat), .missed(missed), .phase(phase), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; beat_ack = 1'b0; period = '0; div = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] obs, exp;
    reset = 1'b1; enable = 1'b1; beat_ack = 1'b1; period = 8'd3; div = 4'd2;
    tick();
    obs = {busy, beat, missed, phase}; exp = {1'b0, 1'b0, 1'b0, 8'd0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_state got %h want %h", obs, exp); end
    tick();
    obs = {busy, beat, missed, phase};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_held got %h want %h", obs, exp); end
    reset = 1'b0; enable = 1'b0;
  endtask

  task automatic test_basic_period();
    logic [10:0] obs, exp;
    do_reset();
    period = 8'd3; div = 4'd0; enable = 1'b1;
    tick();
    obs = {busy, beat, missed, phase}; exp = {1'b1, 1'b0, 1'b0, 8'd3};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL basic_accept got %h want %h", obs, exp); end
    for (int e = 1; e <= 9; e++) begin
      beat_ack = beat;
      tick();
      obs = {busy, beat, missed, phase};
      exp = {1'b1, (e % 3 == 0), 1'b0, (e % 3 == 0) ? 8'd3 : 8'(3 - e % 3)};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL basic_edge%0d got %h want %h", e, obs, exp); end
    end
    beat_ack = 1'b0;
  endtask

  task automatic test_prescaler();
    logic [10:0] obs, exp;
    do_reset();
    period = 8'd2; div = 4'd1; enable = 1'b1;
    tick();
    obs = {busy, beat, missed, phase}; exp = {1'b1, 1'b0, 1'b0, 8'd2};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL presc_accept got %h want %h", obs, exp); end
    for (int e = 1; e <= 8; e++) begin
      beat_ack = beat;
      tick();
      obs = {busy, beat, missed, phase};
      exp = {1'b1, (e % 4 == 0), 1'b0, ((e / 2) % 2 == 1) ? 8'd1 : 8'd2};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL presc_edge%0d got %h want %h", e, obs, exp); end
    end
    beat_ack = 1'b0;
  endtask

  task automatic test_no_ack();
    logic [10:0] obs, exp;
    do_reset();
    period = 8'd2; div = 4'd0; enable = 1'b1; beat_ack = 1'b0;
    tick();
    for (int e = 1; e <= 8; e++) begin
      tick();
      obs = {busy, beat, missed, phase};
      exp = {1'b1, (e >= 2), (e >= 4 && e % 2 == 0), (e % 2 == 0) ? 8'd2 : 8'd1};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL noack_edge%0d got %h want %h", e, obs, exp); end
    end
    beat_ack = 1'b1;
    tick();
    obs = {busy, beat, missed, phase}; exp = {1'b1, 1'b0, 1'b0, 8'd1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL noack_late_ack got %h want %h", obs, exp); end
    beat_ack = 1'b0;
    tick();
    obs = {busy, beat, missed, phase}; exp = {1'b1, 1'b1, 1'b0, 8'd2};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL noack_rebeat got %h want %h", obs, exp); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] obs, exp;
    do_reset();
    period = 8'd2; div = 4'd0; enable = 1'b1; beat_ack = 1'b0;
    tick(); tick(); tick();
    obs = {busy, beat, missed, phase}; exp = {1'b1, 1'b1, 1'b0, 8'd2};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL b2b_first got %h want %h", obs, exp); end
    tick();
    beat_ack = 1'b1;
    tick();
    obs = {busy, beat, missed, phase}; exp = {1'b1, 1'b1, 1'b0, 8'd2};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL b2b_ack_on_due got %h want %h", obs, exp); end
    tick();
    obs = {busy, beat, missed, phase}; exp = {1'b1, 1'b0, 1'b0, 8'd1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL b2b_clear got %h want %h", obs, exp); end
    beat_ack = 1'b0;
  endtask

  task automatic test_period_zero();
    logic [10:0] obs, exp;
    do_reset();
    period = 8'd0; div = 4'd0; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      obs = {busy, beat, missed, phase}; exp = '0;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL pzero_idle%0d got %h want %h", i, obs, exp); end
    end
    period = 8'd5;
    tick();
    obs = {busy, beat, missed, phase}; exp = {1'b1, 1'b0, 1'b0, 8'd5};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL pzero_start got %h want %h", obs, exp); end
    period = 8'd0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      obs = {busy, beat, missed, phase}; exp = {1'b1, 1'b0, 1'b0, 8'(5 - e)};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL pzero_count%0d got %h want %h", e, obs, exp); end
    end
    tick();
    obs = {busy, beat, missed, phase}; exp = {1'b0, 1'b1, 1'b0, 8'd0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL pzero_stop got %h want %h", obs, exp); end
    tick();
    checks++;
    if (obs !== {busy, beat, missed, phase}) begin
      errors++; $display("FAIL pzero_hold got %h want %h", {busy, beat, missed, phase}, obs);
    end
    beat_ack = 1'b1;
    tick();
    obs = {busy, beat, missed, phase}; exp = '0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL pzero_ack got %h want %h", obs, exp); end
    beat_ack = 1'b0; enable = 1'b0;
  endtask

  task automatic test_disable_mid_run();
    logic [10:0] obs, exp;
    do_reset();
    period = 8'd2; div = 4'd0; enable = 1'b1; beat_ack = 1'b0;
    tick(); tick(); tick(); tick();
    obs = {busy, beat, missed, phase}; exp = {1'b1, 1'b1, 1'b0, 8'd1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL dis_pre got %h want %h", obs, exp); end
    enable = 1'b0;
    tick();
    obs = {busy, beat, missed, phase}; exp = {1'b0, 1'b1, 1'b0, 8'd0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL dis_idle got %h want %h", obs, exp); end
    tick();
    obs = {busy, beat, missed, phase};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL dis_held got %h want %h", obs, exp); end
    beat_ack = 1'b1;
    tick();
    obs = {busy, beat, missed, phase}; exp = '0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL dis_ack got %h want %h", obs, exp); end
    beat_ack = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [10:0] obs, exp;
    do_reset();
    period = 8'd2; div = 4'd0; enable = 1'b1; beat_ack = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    obs = {busy, beat, missed, phase}; exp = {1'b1, 1'b1, 1'b1, 8'd2};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_pre got %h want %h", obs, exp); end
    reset = 1'b1;
    tick();
    obs = {busy, beat, missed, phase}; exp = '0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_mid got %h want %h", obs, exp); end
    reset = 1'b0; enable = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; beat_ack = 1'b0; period = '0; div = '0;
    test_reset();
    test_basic_period();
    test_prescaler();
    test_no_ack();
    test_back_to_back();
    test_period_zero();
    test_disable_mid_run();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
